// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared constants for the RS(255,239,T=8) datapath over GF(2^8):
// field polynomial, code dimensions, alpha power table, state encodings and
// a GF(2^8) multiply helper. Used by the encoder, syndrome and locator stages.
// Ports: none (package).
// ---------------------------------------------------------------------------
package rs_pkg;

    localparam int RS_M = 8;
    localparam int RS_N = 255;
    localparam int RS_K = 239;
    localparam int RS_T = 8;

    localparam logic [8:0] FIELD_POLY = 9'h11D;

    // alpha^j for j = 0..15, element [0] = alpha^0
    localparam logic [15:0][7:0] ALPHA_POW = {
        8'h26, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D,
        8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    localparam logic [0:0] S_ACC = 1'b0;
    localparam logic [0:0] S_OUT = 1'b1;

    // Shift-and-add multiply; with a constant b this folds to an XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ FIELD_POLY[7:0]) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_syndrome_if.sv
// ---------------------------------------------------------------------------
// rs_syndrome_if
// Byte-input / syndrome-output bundle for the RS syndrome stage.
//   in_byte, in_valid, in_ready      : received symbol stream (valid/ready)
//   syn_out, syn_idx, syn_valid,
//   syn_last, err                    : syndrome stream, no backpressure
// master = upstream/downstream environment, slave = rs_syndrome.
// ---------------------------------------------------------------------------
interface rs_syndrome_if #(
    parameter int M = 8,
    parameter int T = 8
);
    localparam int IW = $clog2(2 * T);

    logic [M-1:0]  in_byte;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  syn_out;
    logic [IW-1:0] syn_idx;
    logic          syn_valid;
    logic          syn_last;
    logic          err;

    modport master (
        output in_byte, in_valid,
        input  in_ready, syn_out, syn_idx, syn_valid, syn_last, err
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, syn_out, syn_idx, syn_valid, syn_last, err
    );
endinterface

// File: rtl/rs_syn_cmul.sv
// ---------------------------------------------------------------------------
// rs_syn_cmul
// Combinational GF(2^8) multiply by the constant alpha^J (poly 0x11D).
//   a : operand in
//   y : a * alpha^J
// ---------------------------------------------------------------------------
module rs_syn_cmul
    import rs_pkg::*;
#(
    parameter int J = 0
) (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] K_ALPHA = ALPHA_POW[J];

    always_comb y = gf_mul(a, K_ALPHA);
endmodule

// File: rtl/rs_syndrome.sv
// ---------------------------------------------------------------------------
// rs_syndrome
// Evaluates S_j = r(alpha^j), j = 0..2T-1, over one received codeword using
// Horner's rule (first byte is the highest-degree coefficient), then streams
// the 2T syndromes out on consecutive cycles with an error flag on the last.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : rs_syndrome_if.slave (byte input, syndrome output)
//
// state | meaning
// S_ACC | accepting bytes, updating all syndromes per byte
// S_OUT | presenting syndrome out_ct, input stalled
// ---------------------------------------------------------------------------
module rs_syndrome
    import rs_pkg::*;
#(
    parameter int N = RS_N,
    parameter int T = RS_T,
    parameter int M = RS_M
) (
    input  logic          clk,
    input  logic          reset_n,
    rs_syndrome_if.slave  bus
);
    localparam int NSYN = 2 * T;
    localparam int IW   = $clog2(NSYN);
    localparam logic [7:0]    BYTE_LAST = 8'(N - 1);
    localparam logic [IW-1:0] OUT_LAST  = IW'(NSYN - 1);

    logic [0:0]    state;
    logic [7:0]    byte_ct;
    logic [IW-1:0] out_ct;
    logic [IW-1:0] nxt_ct;
    logic [M-1:0]  s     [NSYN];
    logic [M-1:0]  s_mul [NSYN];
    logic [M-1:0]  s_nxt_out;
    logic [M-1:0]  syn_q;
    logic          last_q;
    logic          err_q;
    logic          err_acc;

    for (genvar g = 0; g < NSYN; g++) begin : g_cmul
        rs_syn_cmul #(.J(g)) u_cmul (
            .a (s[g]),
            .y (s_mul[g])
        );
    end

    assign nxt_ct    = out_ct + 1'b1;
    assign s_nxt_out = s[nxt_ct];

    // syn_q always holds S[out_ct] while in S_OUT, so it is loaded one step
    // ahead: with the finished S_0 on the last input byte, then S[out_ct+1].
    // err_acc covers indices already emitted before the current one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_ACC;
            byte_ct <= '0;
            out_ct  <= '0;
            err_acc <= 1'b0;
            syn_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int j = 0; j < NSYN; j++) s[j] <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (bus.in_valid) begin
                        for (int j = 0; j < NSYN; j++) s[j] <= s_mul[j] ^ bus.in_byte;
                        if (byte_ct == BYTE_LAST) begin
                            byte_ct <= '0;
                            out_ct  <= '0;
                            state   <= S_OUT;
                            syn_q   <= s_mul[0] ^ bus.in_byte;
                            last_q  <= 1'b0;
                            err_q   <= 1'b0;
                        end else begin
                            byte_ct <= byte_ct + 8'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ct == OUT_LAST) begin
                        for (int j = 0; j < NSYN; j++) s[j] <= '0;
                        err_acc <= 1'b0;
                        out_ct  <= '0;
                        syn_q   <= '0;
                        last_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state   <= S_ACC;
                    end else begin
                        out_ct  <= nxt_ct;
                        syn_q   <= s_nxt_out;
                        err_acc <= err_acc | (syn_q != '0);
                        last_q  <= (nxt_ct == OUT_LAST);
                        err_q   <= (nxt_ct == OUT_LAST) &
                                   (err_acc | (syn_q != '0) | (s_nxt_out != '0));
                    end
                end
                default: begin
                    state   <= S_ACC;
                    byte_ct <= '0;
                    out_ct  <= '0;
                    err_acc <= 1'b0;
                    syn_q   <= '0;
                    last_q  <= 1'b0;
                    err_q   <= 1'b0;
                    for (int j = 0; j < NSYN; j++) s[j] <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == S_ACC);
    assign bus.syn_valid = (state == S_OUT);
    assign bus.syn_idx   = out_ct;
    assign bus.syn_out   = syn_q;
    assign bus.syn_last  = last_q;
    assign bus.err       = err_q;
endmodule

// File: doc/rs_syndrome.md
# rs_syndrome

Receive-side front end for the systematic RS(255,239,T=8) code over GF(2^8), p(x) = x^8+x^4+x^3+x^2+1, generator roots alpha^0..alpha^(2T-1), alpha = 0x02. It accepts one received codeword a byte at a time and evaluates the 2T syndromes S_j = r(alpha^j) by Horner's rule. It then streams the syndromes out with an error flag. It sits after byte deframing and ahead of the error locator / correction stage, and is the check that the encoder's output forms a valid codeword.

## Interface
- N, 255, codeword length in bytes; N < 255 supports shortened codes
- T, 8, correctable symbols; 2T syndromes are produced
- M, 8, symbol width; fixed at 8 for this field
- clk  in  1  single clock; all state updates on posedge
- reset_n  in  1  reset; asynchronous, active-low
- in_byte  in  M  received symbol; first byte is the x^(N-1) coefficient
- in_valid  in  1  in_byte is valid this cycle
- in_ready  out  1  block accepts a byte; a transfer occurs when in_valid & in_ready
- syn_out  out  M  syndrome value
- syn_idx  out  log2(2T)  syndrome index j
- syn_valid  out  1  syn_out/syn_idx are valid
- syn_last  out  1  asserted with j = 2T-1
- err  out  1  at least one syndrome of this codeword is nonzero; meaningful only with syn_last

## Operation
- States:
  - S_ACC: accumulating the codeword.
  - S_OUT: emitting syndromes.
- The state encoding leaves no unused reachable states. Any illegal encoding returns to S_ACC.
- S_ACC:
  - in_ready = 1.
  - On each transfer, for every j: S_j <= (S_j * alpha^j) ^ in_byte, using GF(2^8) constant multiplication. S_0 is therefore a plain XOR accumulate.
  - byte_ct (8 bits) increments on each transfer.
  - On the transfer with byte_ct = N-1, byte_ct clears and the state moves to S_OUT.
- Gaps: in_valid may drop at any point within a codeword. Registers hold their values and no timeout applies.
- S_OUT:
  - in_ready = 0. in_valid is ignored and no data is consumed.
  - out_ct (log2(2T) bits) counts 0..2T-1.
  - Each cycle: syn_valid = 1, syn_idx = out_ct, syn_out = S_out_ct.
  - An err_acc register ORs together the nonzero-ness of each emitted syndrome.
  - err = err_acc | (S_out_ct != 0), asserted together with syn_last.
  - When out_ct = 2T-1: syn_last = 1, then all S_j, err_acc and out_ct clear, and the state returns to S_ACC.
- The output side has no backpressure. The downstream stage must accept 2T consecutive syndromes.
- Width rules: all GF arithmetic is M bits, and addition is XOR. The counters wrap naturally, but their terminal-count compares use N-1 and 2T-1 explicitly.

## Timing
- Reset values:
  - in_ready = 1
  - syn_out = 0, syn_idx = 0
  - syn_valid = 0, syn_last = 0, err = 0
  - all S_j = 0, byte_ct = 0, out_ct = 0
  - state = S_ACC
- Outputs are registered.
- Latency: syn_idx 0 is valid on the cycle after the posedge that accepts byte N-1. syn_last follows 2T-1 cycles later.
- in_ready rises in the cycle after syn_last. A byte presented in that cycle is accepted as byte 0 of the next codeword.
- Minimum period is N+2T cycles per codeword.
- Reset mid-codeword or mid-S_OUT discards partial state immediately. No partial syndromes are emitted afterwards.

## Structure
- rs_pkg holds the shared constants:
  - field polynomial 0x11D
  - N=255, K=239, T=8
  - alpha power table alpha^0..alpha^15
  - state encodings
- rs_pkg is shared with the encoder and the later locator stage.
- Sub-module rs_syn_cmul: combinational multiply by a constant alpha^j (parameter J), reduced by 0x11D. It is instantiated 2T times.

## Test plan
- Reset, then an all-zero codeword of 255 bytes:
  - 16 syndromes, all 0x00, syn_idx 0..15, syn_last with idx 15, err = 0.
  - in_ready is low for exactly 16 cycles.
- Zero codeword with byte 254 (degree 0) = 0x01: all S_j = 0x01 and err = 1.
- Zero codeword with byte 253 (degree 1) = 0x01:
  - S_j = alpha^j, giving S0 = 0x01, S1 = 0x02, S7 = 0x80, S8 = 0x1D, S15 = 0x26.
  - err = 1.
- A valid codeword from the team encoder, first with continuous in_valid and then with in_valid toggling every other cycle:
  - all syndromes 0x00 and err = 0 in both runs.
  - A single byte XOR 0x5A at degree 0 then gives all S_j = 0x5A.
- Mid-codeword reset, then in_valid held high during S_OUT:
  - After reset_n deasserts and a fresh zero codeword is sent, the syndromes are all zero.
  - The bytes driven during S_OUT are not consumed, checked by byte count on the next codeword.
